wb_ppfifo_to_mem: RTL and testbench

Wishbone bus-master DMA engine that drains a ping-pong FIFO (PPFIFO) read port and writes each 32-bit word into one of two host-armed memory buffers, alternating between them. It sits between a streaming producer (e.g. camera capture) and the memory arbiter. A Wishbone slave wrapper programs buffer base/size and reads back counts, empty flags and completion pulses.

---
 rtl/wb_ppfifo_to_mem.sv | 187 ++++++++++++++++++
 tb/tb_wb_ppfifo_to_mem.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ppfifo_to_mem.sv
// wb_ppfifo_to_mem: Wishbone master that drains a ping-pong FIFO block into
// two host-armed memory buffers, switching buffers as each one fills.
`timescale 1ns/1ps
`default_nettype none

module wb_ppfifo_to_mem #(
  parameter logic [31:0] DEFAULT_MEM_0_BASE = 32'h0000_0000,
  parameter logic [31:0] DEFAULT_MEM_1_BASE = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] debug,
  input  logic        i_enable,
  input  logic [31:0] i_memory_0_base,
  input  logic [31:0] i_memory_0_size,
  input  logic        i_memory_0_ready,
  output logic [31:0] o_memory_0_count,
  output logic        o_memory_0_finished,
  output logic        o_memory_0_empty,
  output logic [31:0] o_default_mem_0_base,
  input  logic [31:0] i_memory_1_base,
  input  logic [31:0] i_memory_1_size,
  input  logic        i_memory_1_ready,
  output logic [31:0] o_memory_1_count,
  output logic        o_memory_1_finished,
  output logic        o_memory_1_empty,
  output logic [31:0] o_default_mem_1_base,
  output logic        o_write_finished,
  output logic        o_mem_we,
  output logic        o_mem_stb,
  output logic        o_mem_cyc,
  output logic [3:0]  o_mem_sel,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_dat,
  input  logic [31:0] i_mem_dat,
  input  logic        i_mem_ack,
  input  logic        i_mem_int,
  input  logic        i_ppfifo_rdy,
  output logic        o_ppfifo_act,
  input  logic [23:0] i_ppfifo_size,
  output logic        o_ppfifo_stb,
  input  logic [31:0] i_ppfifo_data
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WRITE    = 4'd1,
    POP      = 4'd2,
    WAIT_ACK = 4'd3
  } state_t;

  state_t state, next_state;

  logic [1:0][31:0] base_q, size_q, count_q;
  logic [1:0][31:0] in_base, in_size;
  logic [1:0]       in_ready, arm, empty_q, fin_q;
  logic             active_q, wbuf_q, cyc_q, act_q, wr_fin_q;
  logic [31:0]      adr_q, dat_q, count_inc;
  logic [23:0]      rd_count_q;
  logic             sel, any_armed, start, issue, ack_ev, done, hit;
  logic             unused_ok;

  assign in_base  = {i_memory_1_base, i_memory_0_base};
  assign in_size  = {i_memory_1_size, i_memory_0_size};
  assign in_ready = {i_memory_1_ready, i_memory_0_ready};
  assign arm      = {in_ready[1] && (in_size[1] != 32'd0),
                     in_ready[0] && (in_size[0] != 32'd0)};

  assign any_armed = ~&empty_q;
  // Effective buffer: leave an empty active buffer as soon as the other is armed.
  assign sel = (empty_q[active_q] && !empty_q[~active_q]) ? ~active_q : active_q;

  assign start  = (state == IDLE) && i_enable && i_ppfifo_rdy && !act_q &&
                  (i_ppfifo_size != 24'd0) && any_armed;
  assign issue  = (state == WRITE) && !cyc_q;
  assign ack_ev = (state == WRITE) && cyc_q && i_mem_ack;
  assign done   = (state == WAIT_ACK) && !i_mem_ack && (rd_count_q == i_ppfifo_size);

  assign count_inc = count_q[wbuf_q] + 32'd1;
  assign hit       = ack_ev && (count_inc == size_q[wbuf_q]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = WRITE;
      WRITE:    if (ack_ev) next_state = POP;
      POP:      next_state = WAIT_ACK;
      WAIT_ACK: begin
        if (done)                                      next_state = IDLE;
        else if (!i_mem_ack && i_enable && any_armed)  next_state = WRITE;
      end
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q     <= '0;
      size_q     <= '0;
      count_q    <= '0;
      empty_q    <= 2'b11;
      fin_q      <= 2'b00;
      active_q   <= 1'b0;
      wbuf_q     <= 1'b0;
      cyc_q      <= 1'b0;
      act_q      <= 1'b0;
      wr_fin_q   <= 1'b0;
      adr_q      <= 32'd0;
      dat_q      <= 32'd0;
      rd_count_q <= 24'd0;
    end else begin
      fin_q    <= 2'b00;
      wr_fin_q <= 1'b0;

      // Address and data are captured once, so a re-arm mid-write cannot move them.
      if (issue) begin
        cyc_q  <= 1'b1;
        wbuf_q <= sel;
        adr_q  <= base_q[sel] + count_q[sel];
        dat_q  <= i_ppfifo_data;
      end else if (ack_ev) begin
        cyc_q <= 1'b0;
      end

      if (start) begin
        act_q      <= 1'b1;
        rd_count_q <= 24'd0;
      end else if (done) begin
        act_q    <= 1'b0;
        wr_fin_q <= 1'b1;
      end else if (ack_ev) begin
        rd_count_q <= rd_count_q + 24'd1;
      end

      if (ack_ev) count_q[wbuf_q] <= count_inc;
      if (hit) begin
        fin_q[wbuf_q]   <= 1'b1;
        empty_q[wbuf_q] <= 1'b1;
      end

      // Arming comes last so it overrides a finish on the same buffer.
      for (int n = 0; n < 2; n++) begin
        if (arm[n]) begin
          base_q[n]  <= in_base[n];
          size_q[n]  <= in_size[n];
          count_q[n] <= 32'd0;
          empty_q[n] <= 1'b0;
        end
      end

      active_q <= hit ? ~wbuf_q : sel;
    end
  end

  assign o_mem_cyc = cyc_q;
  assign o_mem_stb = cyc_q;
  assign o_mem_we  = cyc_q;
  assign o_mem_sel = cyc_q ? 4'hF : 4'h0;
  assign o_mem_adr = adr_q;
  assign o_mem_dat = dat_q;

  assign o_ppfifo_act     = act_q;
  assign o_ppfifo_stb     = (state == POP);
  assign o_write_finished = wr_fin_q;

  assign o_memory_0_count    = count_q[0];
  assign o_memory_1_count    = count_q[1];
  assign o_memory_0_finished = fin_q[0];
  assign o_memory_1_finished = fin_q[1];
  assign o_memory_0_empty    = empty_q[0];
  assign o_memory_1_empty    = empty_q[1];

  assign o_default_mem_0_base = DEFAULT_MEM_0_BASE;
  assign o_default_mem_1_base = DEFAULT_MEM_1_BASE;

  assign debug = {23'd0, empty_q[1], empty_q[0], active_q, i_ppfifo_rdy, act_q, state};

  assign unused_ok = ^{i_mem_dat, i_mem_int};

endmodule

`default_nettype wire

// File: tb/tb_wb_ppfifo_to_mem.sv
// tb_wb_ppfifo_to_mem: directed and randomized checks of the PPFIFO-to-memory
// DMA against a word-level buffer model.
`timescale 1ns/1ps
`default_nettype none

module tb_wb_ppfifo_to_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] debug;
  logic        i_enable = 1'b1;
  logic [31:0] i_memory_0_base = '0, i_memory_0_size = '0;
  logic [31:0] i_memory_1_base = '0, i_memory_1_size = '0;
  logic        i_memory_0_ready = 1'b0, i_memory_1_ready = 1'b0;
  logic [31:0] o_memory_0_count, o_memory_1_count;
  logic        o_memory_0_finished, o_memory_1_finished;
  logic        o_memory_0_empty, o_memory_1_empty;
  logic [31:0] o_default_mem_0_base, o_default_mem_1_base;
  logic        o_write_finished;
  logic        o_mem_we, o_mem_stb, o_mem_cyc;
  logic [3:0]  o_mem_sel;
  logic [31:0] o_mem_adr, o_mem_dat;
  logic [31:0] i_mem_dat = '0;
  logic        i_mem_ack;
  logic        i_mem_int = 1'b0;
  logic        i_ppfifo_rdy = 1'b0;
  logic        o_ppfifo_act;
  logic [23:0] i_ppfifo_size = '0;
  logic        o_ppfifo_stb;
  logic [31:0] i_ppfifo_data;

  always #5 clk = ~clk;

  wb_ppfifo_to_mem dut (
    .clk(clk), .rst(rst), .debug(debug), .i_enable(i_enable),
    .i_memory_0_base(i_memory_0_base), .i_memory_0_size(i_memory_0_size),
    .i_memory_0_ready(i_memory_0_ready), .o_memory_0_count(o_memory_0_count),
    .o_memory_0_finished(o_memory_0_finished), .o_memory_0_empty(o_memory_0_empty),
    .o_default_mem_0_base(o_default_mem_0_base),
    .i_memory_1_base(i_memory_1_base), .i_memory_1_size(i_memory_1_size),
    .i_memory_1_ready(i_memory_1_ready), .o_memory_1_count(o_memory_1_count),
    .o_memory_1_finished(o_memory_1_finished), .o_memory_1_empty(o_memory_1_empty),
    .o_default_mem_1_base(o_default_mem_1_base),
    .o_write_finished(o_write_finished), .o_mem_we(o_mem_we), .o_mem_stb(o_mem_stb),
    .o_mem_cyc(o_mem_cyc), .o_mem_sel(o_mem_sel), .o_mem_adr(o_mem_adr),
    .o_mem_dat(o_mem_dat), .i_mem_dat(i_mem_dat), .i_mem_ack(i_mem_ack),
    .i_mem_int(i_mem_int), .i_ppfifo_rdy(i_ppfifo_rdy), .o_ppfifo_act(o_ppfifo_act),
    .i_ppfifo_size(i_ppfifo_size), .o_ppfifo_stb(o_ppfifo_stb), .i_ppfifo_data(i_ppfifo_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave: ack after a programmable delay, held until stb drops.
  bit ack_rand = 1'b0;
  int ack_fix  = 1;
  initial begin
    int dly;
    bit pend;
    i_mem_ack = 1'b0;
    dly = 0;
    pend = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!o_mem_stb) begin
        i_mem_ack = 1'b0;
        pend = 1'b0;
      end else if (!i_mem_ack) begin
        if (!pend) begin
          dly  = ack_rand ? int'($urandom_range(0, 5)) : ack_fix;
          pend = 1'b1;
        end
        if (dly == 0) i_mem_ack = 1'b1;
        else          dly--;
      end
    end
  end

  // PPFIFO source: first-word fall-through view of the current block.
  logic [31:0] blk [16];
  int          pop_cnt = 0;
  int          pop_base = 0;
  logic [3:0]  pidx;
  assign pidx = 4'(pop_cnt - pop_base);
  assign i_ppfifo_data = blk[pidx];

  // Monitor: records completed writes and counts pulses.
  logic [31:0] obs_adr [2048];
  logic [31:0] obs_dat [2048];
  logic [31:0] cap_adr [2048];
  logic [31:0] cap_dat [2048];
  logic [3:0]  obs_sel [2048];
  int obs_n = 0;
  int fin_cnt0 = 0, fin_cnt1 = 0, wf_cnt = 0;
  initial begin
    logic prev;
    logic [31:0] ca, cd;
    prev = 1'b0; ca = '0; cd = '0;
    forever begin
      @(negedge clk);
      if (o_mem_stb && !prev) begin
        ca = o_mem_adr;
        cd = o_mem_dat;
      end
      if (o_mem_stb && i_mem_ack && obs_n < 2048) begin
        obs_adr[obs_n] = o_mem_adr;
        obs_dat[obs_n] = o_mem_dat;
        obs_sel[obs_n] = o_mem_sel;
        cap_adr[obs_n] = ca;
        cap_dat[obs_n] = cd;
        obs_n++;
      end
      if (o_ppfifo_stb)        pop_cnt++;
      if (o_memory_0_finished) fin_cnt0++;
      if (o_memory_1_finished) fin_cnt1++;
      if (o_write_finished)    wf_cnt++;
      prev = o_mem_stb;
    end
  end

  // Word-level reference: two buffers, each word lands at base+count of the
  // buffer in use; a full or unarmed buffer hands over to the other one.
  logic [31:0] m_base [2];
  logic [31:0] m_size [2];
  logic [31:0] m_cnt  [2];
  bit          m_arm  [2];
  int          m_a = 0;
  int          fin_exp [2];
  int          wf_exp = 0;
  int          cons = 0;
  int          wr_idx = 0;

  task automatic normalize();
    if (!m_arm[m_a] && m_arm[1-m_a]) m_a = 1 - m_a;
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_arm[n] = 1'b0;
      m_cnt[n] = '0;
    end
    m_a = 0;
  endtask

  task automatic drain();
    while (cons < obs_n) begin
      chk("adr_stable", obs_adr[cons], cap_adr[cons]);
      chk("dat_stable", obs_dat[cons], cap_dat[cons]);
      chk("sel", 32'(obs_sel[cons]), 32'hF);
      normalize();
      chk("write_target_armed", 32'(m_arm[0] | m_arm[1]), 32'd1);
      if (m_arm[m_a]) begin
        chk("adr", obs_adr[cons], m_base[m_a] + m_cnt[m_a]);
        chk("dat", obs_dat[cons], blk[wr_idx & 15]);
        m_cnt[m_a] = m_cnt[m_a] + 32'd1;
        if (m_cnt[m_a] == m_size[m_a]) begin
          m_arm[m_a] = 1'b0;
          fin_exp[m_a]++;
          m_a = 1 - m_a;
          normalize();
        end
      end
      wr_idx++;
      cons++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
    if (o_ppfifo_act) i_ppfifo_rdy = 1'b0;
  endtask

  task automatic arm(input int n, input logic [31:0] b, input logic [31:0] s);
    if (n == 0) begin
      i_memory_0_base = b; i_memory_0_size = s; i_memory_0_ready = 1'b1;
    end else begin
      i_memory_1_base = b; i_memory_1_size = s; i_memory_1_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    drain();
    i_memory_0_ready = 1'b0;
    i_memory_1_ready = 1'b0;
    if (s != 0) begin
      m_base[n] = b; m_size[n] = s; m_cnt[n] = '0; m_arm[n] = 1'b1;
    end
    normalize();
  endtask

  task automatic start_block(input int len);
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    pop_base = pop_cnt;
    wr_idx = 0;
    i_ppfifo_size = 24'(len);
    i_ppfifo_rdy = 1'b1;
  endtask

  task automatic check_all(input int len);
    chk("pops", 32'(pop_cnt - pop_base), 32'(len));
    chk("writes", 32'(wr_idx), 32'(len));
    chk("count0", o_memory_0_count, m_cnt[0]);
    chk("count1", o_memory_1_count, m_cnt[1]);
    chk("empty0", 32'(o_memory_0_empty), 32'(!m_arm[0]));
    chk("empty1", 32'(o_memory_1_empty), 32'(!m_arm[1]));
    chk("act_idle", 32'(o_ppfifo_act), 32'd0);
    chk("cyc_idle", 32'(o_mem_cyc), 32'd0);
    chk("fin0_pulses", 32'(fin_cnt0), 32'(fin_exp[0]));
    chk("fin1_pulses", 32'(fin_cnt1), 32'(fin_exp[1]));
    chk("wf_pulses", 32'(wf_cnt), 32'(wf_exp));
    chk("dbg_active", 32'(debug[6]), 32'(m_a));
    chk("dbg_empty", 32'(debug[8:7]), {30'd0, !m_arm[1], !m_arm[0]});
  endtask

  task automatic finish_block(input bit auto_arm, input int len);
    int t;
    t = 0;
    while (wf_cnt <= wf_exp && t < 3000) begin
      tick();
      if (auto_arm && !m_arm[0] && !m_arm[1] && wr_idx < len)
        arm(int'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 8,
            32'($urandom_range(1, 4)));
      t++;
    end
    chk("block_done", 32'(wf_cnt), 32'(wf_exp + 1));
    wf_exp++;
    i_ppfifo_rdy = 1'b0;
    tick();
    tick();
    check_all(len);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    i_ppfifo_rdy = 1'b0;
    i_memory_0_ready = 1'b0;
    i_memory_1_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    tick();
  endtask

  initial begin
    int t;
    int len;
    fin_exp[0] = 0;
    fin_exp[1] = 0;
    model_reset();
    for (int i = 0; i < 16; i++) blk[i] = '0;

    // Reset state
    #12;
    chk("rst_cyc", 32'(o_mem_cyc), 32'd0);
    chk("rst_stb", 32'(o_mem_stb), 32'd0);
    chk("rst_act", 32'(o_ppfifo_act), 32'd0);
    chk("rst_pop", 32'(o_ppfifo_stb), 32'd0);
    chk("rst_count0", o_memory_0_count, 32'd0);
    chk("rst_count1", o_memory_1_count, 32'd0);
    chk("rst_empty", {30'd0, o_memory_1_empty, o_memory_0_empty}, 32'd3);
    chk("rst_wf", 32'(o_write_finished), 32'd0);
    chk("def_base0", o_default_mem_0_base, 32'h0000_0000);
    chk("def_base1", o_default_mem_1_base, 32'h0010_0000);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Single buffer, exact fit
    arm(0, 32'h100, 32'd4);
    tick();
    start_block(4);
    finish_block(1'b0, 4);
    chk("t1_count0", o_memory_0_count, 32'd4);
    chk("t1_empty0", 32'(o_memory_0_empty), 32'd1);
    chk("t1_fin0", 32'(fin_cnt0), 32'd1);

    // Spill from buffer 0 into buffer 1
    arm(0, 32'h000, 32'd2);
    arm(1, 32'h200, 32'd4);
    tick();
    start_block(4);
    finish_block(1'b0, 4);
    chk("t2_count1", o_memory_1_count, 32'd2);
    chk("t2_empty1", 32'(o_memory_1_empty), 32'd0);

    // Stall when both buffers are full, resume on arming buffer 1
    do_reset();
    arm(0, 32'h40, 32'd2);
    tick();
    start_block(3);
    t = 0;
    while (wr_idx < 2 && t < 200) begin tick(); t++; end
    repeat (8) tick();
    chk("t3_stall_writes", 32'(wr_idx), 32'd2);
    chk("t3_act_held", 32'(o_ppfifo_act), 32'd1);
    chk("t3_stb_low", 32'(o_mem_stb), 32'd0);
    arm(1, 32'h300, 32'd5);
    finish_block(1'b0, 3);

    // Enable gating and start latency
    arm(0, 32'h500, 32'd3);
    i_enable = 1'b0;
    start_block(2);
    repeat (6) tick();
    chk("t4_act_off", 32'(o_ppfifo_act), 32'd0);
    chk("t4_cyc_off", 32'(o_mem_cyc), 32'd0);
    i_enable = 1'b1;
    tick();
    chk("t4_act_lat", 32'(o_ppfifo_act), 32'd1);
    chk("t4_cyc_lat1", 32'(o_mem_cyc), 32'd0);
    tick();
    chk("t4_cyc_lat2", 32'(o_mem_cyc), 32'd1);
    finish_block(1'b0, 2);

    // Re-arm in the same cycle as the finishing write
    do_reset();
    ack_fix = 2;
    arm(0, 32'h900, 32'd2);
    tick();
    start_block(3);
    t = 0;
    while (wr_idx < 1 && t < 200) begin tick(); t++; end
    t = 0;
    while (!o_mem_stb && t < 200) begin tick(); t++; end
    tick();
    tick();
    arm(0, 32'hA00, 32'd4);
    finish_block(1'b0, 3);
    chk("t6_count0", o_memory_0_count, 32'd1);
    chk("t6_empty0", 32'(o_memory_0_empty), 32'd0);
    ack_fix = 1;

    // Randomized blocks, buffers and slave latency
    ack_rand = 1'b1;
    for (int it = 0; it < 30; it++) begin
      for (int n = 0; n < 2; n++)
        if ($urandom_range(0, 2) == 0)
          arm(n, 32'($urandom_range(0, 255)) << 8, 32'($urandom_range(0, 6)));
      tick();
      len = int'($urandom_range(1, 8));
      start_block(len);
      finish_block(1'b1, len);
    end

    // Asynchronous reset in the middle of a block
    do_reset();
    ack_rand = 1'b0;
    arm(0, 32'h700, 32'd8);
    tick();
    start_block(8);
    t = 0;
    while (wr_idx < 3 && t < 300) begin tick(); t++; end
    #1 rst = 1'b0;
    #1;
    chk("t5_cyc", 32'(o_mem_cyc), 32'd0);
    chk("t5_act", 32'(o_ppfifo_act), 32'd0);
    chk("t5_pop", 32'(o_ppfifo_stb), 32'd0);
    chk("t5_empty", {30'd0, o_memory_1_empty, o_memory_0_empty}, 32'd3);
    chk("t5_count0", o_memory_0_count, 32'd0);
    i_ppfifo_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    arm(1, 32'h800, 32'd3);
    tick();
    start_block(3);
    finish_block(1'b0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
